// File: rtl/lzd_pipe.sv
// lzd_pipe: two-stage pipelined leading-zero / leading-one detector with
// left normalisation and a valid/ready stream interface.
// Stage 1 computes per-byte leading-zero counts on the (possibly inverted)
// operand; stage 2 merges them from the MSB, shifts the original operand and
// registers the result.
module lzd_pipe #(
    parameter int W     = 32,
    parameter int TAG_W = 4,
    parameter int CW    = $clog2(W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_cnt,
    output logic             out_v,
    output logic [W-1:0]     out_norm,
    output logic [TAG_W-1:0] out_tag
);

    localparam int NSEG = W / 8;

    // Leading-zero count of one byte; value is don't-care when the byte is zero.
    function automatic logic [2:0] byte_lzc(input logic [7:0] b);
        logic [2:0] c;
        c = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) c = 3'(7 - i);
        end
        return c;
    endfunction

    logic                       s1_valid;
    logic [W-1:0]               s1_data;
    logic [TAG_W-1:0]           s1_tag;
    logic [NSEG-1:0]            s1_segv;
    logic [NSEG-1:0][2:0]       s1_segcnt;

    logic                       s1_adv;
    logic                       s2_adv;

    logic [W-1:0]               scan;
    logic [NSEG-1:0]            segv_d;
    logic [NSEG-1:0][2:0]       segcnt_d;

    logic                       found;
    logic [CW-1:0]              cnt_d;
    logic [W-1:0]               norm_d;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    // Leading-ones mode counts zeros of the inverted word; the shift still uses in_data.
    assign scan = in_mode ? ~in_data : in_data;

    // Per-segment count and valid; segment 0 holds the most significant byte.
    always_comb begin
        segv_d   = '0;
        segcnt_d = '0;
        for (int k = 0; k < NSEG; k++) begin
            segv_d[k]   = |scan[W-1-8*k -: 8];
            segcnt_d[k] = byte_lzc(scan[W-1-8*k -: 8]);
        end
    end

    // Stage 1 registers: load a new beat whenever this stage advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_tag    <= '0;
            s1_segv   <= '0;
            s1_segcnt <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data   <= in_data;
                s1_tag    <= in_tag;
                s1_segv   <= segv_d;
                s1_segcnt <= segcnt_d;
            end
        end
    end

    // Priority merge from the MSB segment; descending loop lets the lowest index win.
    always_comb begin
        int cnt_i;
        found = 1'b0;
        cnt_i = 0;
        for (int k = NSEG - 1; k >= 0; k--) begin
            if (s1_segv[k]) begin
                found = 1'b1;
                cnt_i = 8 * k + int'(s1_segcnt[k]);
            end
        end
        cnt_d  = CW'(cnt_i);
        norm_d = found ? (s1_data << cnt_d) : s1_data;
    end

    // Stage 2 output registers: hold steady while the result is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_cnt   <= '0;
            out_v     <= 1'b0;
            out_norm  <= '0;
            out_tag   <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_cnt  <= cnt_d;
                out_v    <= found;
                out_norm <= norm_d;
                out_tag  <= s1_tag;
            end
        end
    end

endmodule

// File: tb/tb_lzd_pipe.sv
// Testbench for lzd_pipe: directed vectors on a 32-bit instance plus
// randomised streams on 8/16/64-bit instances against a bit-serial model.
module tb_lzd_pipe;

    logic clk;
    logic rst_n;
    logic start_rand;

    int n_chk;
    int n_pass;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // 32-bit directed instance
    logic        d_iv, d_ir, d_im, d_ov, d_ordy, d_v;
    logic [31:0] d_id, d_norm;
    logic [3:0]  d_it, d_ot;
    logic [4:0]  d_cnt;

    lzd_pipe #(.W(32), .TAG_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(d_iv), .in_ready(d_ir), .in_data(d_id), .in_mode(d_im), .in_tag(d_it),
        .out_valid(d_ov), .out_ready(d_ordy), .out_cnt(d_cnt), .out_v(d_v),
        .out_norm(d_norm), .out_tag(d_ot)
    );

    task automatic run_vec(input string nm, input logic [31:0] d, input logic m, input logic [3:0] t,
                           input int ec, input logic ev, input logic [31:0] en);
        @(negedge clk);
        d_iv = 1'b1; d_id = d; d_im = m; d_it = t; d_ordy = 1'b1;
        #1 check({nm, "_in_ready"}, 64'(d_ir), 64'd1);
        @(negedge clk);
        d_iv = 1'b0;
        #1 check({nm, "_lat1"}, 64'(d_ov), 64'd0);
        @(negedge clk);
        #1;
        check({nm, "_valid"}, 64'(d_ov), 64'd1);
        check({nm, "_cnt"}, 64'(d_cnt), 64'(ec));
        check({nm, "_v"}, 64'(d_v), 64'(ev));
        check({nm, "_norm"}, 64'(d_norm), 64'(en));
        check({nm, "_tag"}, 64'(d_ot), 64'(t));
    endtask

    // Randomised instances against a reference model
    for (genvar g = 0; g < 3; g++) begin : gen_r
        localparam int WW = (g == 0) ? 8 : (g == 1) ? 16 : 64;
        localparam int CC = $clog2(WW);

        logic          iv, ir, im, ov, ordy, ovv, done, acc;
        logic [WW-1:0] id, on;
        logic [3:0]    it, ot;
        logic [CC-1:0] oc;
        int            q_cnt[$];
        logic          q_v[$];
        logic [WW-1:0] q_norm[$];
        logic [3:0]    q_tag[$];

        lzd_pipe #(.W(WW), .TAG_W(4)) u_rdut (
            .clk(clk), .rst_n(rst_n),
            .in_valid(iv), .in_ready(ir), .in_data(id), .in_mode(im), .in_tag(it),
            .out_valid(ov), .out_ready(ordy), .out_cnt(oc), .out_v(ovv),
            .out_norm(on), .out_tag(ot)
        );

        function automatic void model(input logic [WW-1:0] d, input logic m,
                                      output int c, output logic v, output logic [WW-1:0] n);
            logic [WW-1:0] x;
            x = m ? ~d : d;
            v = 1'b0;
            c = 0;
            for (int i = WW - 1; i >= 0; i--) begin
                if (!v) begin
                    if (x[i]) v = 1'b1;
                    else c++;
                end
            end
            if (!v) c = 0;
            n = v ? (d << c) : d;
        endfunction

        initial begin
            logic [63:0] r;
            int          ec;
            logic        ev;
            logic [WW-1:0] en;
            iv = 1'b0; id = '0; im = 1'b0; it = '0; ordy = 1'b0; done = 1'b0; acc = 1'b0;
            wait (start_rand === 1'b1);
            for (int cyc = 0; cyc < 400; cyc++) begin
                @(negedge clk);
                if (!iv || acc) begin
                    iv = (cyc < 360) && ($urandom_range(0, 3) != 0);
                    r  = {$urandom, $urandom};
                    r  = r >> $urandom_range(0, WW - 1);
                    if ($urandom_range(0, 9) == 0) r = '0;
                    id = r[63 -: WW];
                    im = $urandom_range(0, 1) == 1;
                    if (im) id = ~id;
                    it = 4'($urandom_range(0, 15));
                end
                ordy = (cyc >= 360) || ($urandom_range(0, 3) != 0);
                #1;
                if (ov && ordy) begin
                    check($sformatf("rand%0d_nonempty", WW), 64'(q_cnt.size() > 0), 64'd1);
                    if (q_cnt.size() > 0) begin
                        check($sformatf("rand%0d_cnt", WW), 64'(oc), 64'(q_cnt.pop_front()));
                        check($sformatf("rand%0d_v", WW), 64'(ovv), 64'(q_v.pop_front()));
                        check($sformatf("rand%0d_norm", WW), 64'(on), 64'(q_norm.pop_front()));
                        check($sformatf("rand%0d_tag", WW), 64'(ot), 64'(q_tag.pop_front()));
                    end
                end
                acc = iv && ir;
                if (acc) begin
                    model(id, im, ec, ev, en);
                    q_cnt.push_back(ec);
                    q_v.push_back(ev);
                    q_norm.push_back(en);
                    q_tag.push_back(it);
                end
            end
            check($sformatf("rand%0d_drained", WW), 64'(q_cnt.size()), 64'd0);
            done = 1'b1;
        end
    end

    initial begin
        int next_tag;
        int exp_tag;
        n_chk = 0; n_pass = 0; start_rand = 1'b0;
        rst_n = 1'b0;
        d_iv = 1'b0; d_id = '0; d_im = 1'b0; d_it = '0; d_ordy = 1'b0;
        #1;
        check("rst_out_valid", 64'(d_ov), 64'd0);
        check("rst_out_cnt", 64'(d_cnt), 64'd0);
        check("rst_out_v", 64'(d_v), 64'd0);
        check("rst_out_norm", 64'(d_norm), 64'd0);
        check("rst_out_tag", 64'(d_ot), 64'd0);
        check("rst_in_ready", 64'(d_ir), 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("post_rst_in_ready", 64'(d_ir), 64'd1);

        run_vec("m0_8000",   32'h0000_8000, 1'b0, 4'd3, 16, 1'b1, 32'h8000_0000);
        run_vec("m0_zero",   32'h0000_0000, 1'b0, 4'd5, 0,  1'b0, 32'h0000_0000);
        run_vec("m1_ones",   32'hFFFF_FFFF, 1'b1, 4'd6, 0,  1'b0, 32'hFFFF_FFFF);
        run_vec("m0_msb",    32'h8000_0001, 1'b0, 4'd7, 0,  1'b1, 32'h8000_0001);
        run_vec("m1_fff0",   32'hFFF0_1234, 1'b1, 4'd9, 12, 1'b1, 32'h0123_4000);
        run_vec("m1_7fff",   32'h7FFF_FFFF, 1'b1, 4'd10, 0, 1'b1, 32'h7FFF_FFFF);
        run_vec("m0_lsb",    32'h0000_0001, 1'b0, 4'd11, 31, 1'b1, 32'h8000_0000);
        run_vec("m0_00ff",   32'h00FF_0000, 1'b0, 4'd12, 8, 1'b1, 32'hFF00_0000);
        run_vec("m1_fe",     32'hFE00_00FF, 1'b1, 4'd13, 7, 1'b1, 32'h0000_7F80);

        // Back-to-back stream of tags 0..7 with out_ready high
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            d_ordy = 1'b1;
            d_iv   = (i < 8);
            d_id   = 32'h1 << (3 * (i % 8));
            d_im   = 1'b0;
            d_it   = 4'(i);
            #1;
            if (i < 8) check($sformatf("stream_in_ready_%0d", i), 64'(d_ir), 64'd1);
            if (i >= 2) begin
                check($sformatf("stream_valid_%0d", i - 2), 64'(d_ov), 64'd1);
                check($sformatf("stream_tag_%0d", i - 2), 64'(d_ot), 64'(i - 2));
                check($sformatf("stream_cnt_%0d", i - 2), 64'(d_cnt), 64'(31 - 3 * (i - 2)));
            end
        end
        @(negedge clk);
        d_iv = 1'b0;
        #1 check("stream_empty", 64'(d_ov), 64'd0);

        // Back-pressure: out_ready low for cycles 0..5, in_valid held
        next_tag = 8;
        exp_tag  = 8;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            d_ordy = (c >= 6);
            d_iv   = (next_tag <= 10);
            d_id   = 32'h1 << next_tag;
            d_im   = 1'b0;
            d_it   = 4'(next_tag);
            #1;
            if (c >= 2 && c <= 5) begin
                check($sformatf("bp_in_ready_%0d", c), 64'(d_ir), 64'd0);
                check($sformatf("bp_valid_%0d", c), 64'(d_ov), 64'd1);
                check($sformatf("bp_tag_%0d", c), 64'(d_ot), 64'd8);
                check($sformatf("bp_norm_%0d", c), 64'(d_norm), 64'h8000_0000);
                check($sformatf("bp_cnt_%0d", c), 64'(d_cnt), 64'd23);
            end
            if (d_ov && d_ordy) begin
                check($sformatf("bp_drain_tag_%0d", exp_tag), 64'(d_ot), 64'(exp_tag));
                check($sformatf("bp_drain_cnt_%0d", exp_tag), 64'(d_cnt), 64'(31 - exp_tag));
                exp_tag++;
            end
            if (d_iv && d_ir) next_tag++;
        end
        check("bp_all_drained", 64'(exp_tag), 64'd11);

        // Asynchronous reset with two beats in flight
        @(negedge clk);
        d_ordy = 1'b0; d_iv = 1'b1; d_id = 32'h0000_00F0; d_it = 4'd12;
        @(negedge clk);
        d_id = 32'h0000_0F00; d_it = 4'd13;
        @(negedge clk);
        d_iv = 1'b0;
        #1;
        check("inflight_valid", 64'(d_ov), 64'd1);
        check("inflight_in_ready", 64'(d_ir), 64'd0);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(d_ov), 64'd0);
        check("async_rst_in_ready", 64'(d_ir), 64'd1);
        check("async_rst_norm", 64'(d_norm), 64'd0);
        check("async_rst_tag", 64'(d_ot), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        d_ordy = 1'b1;
        #1 check("rel_in_ready", 64'(d_ir), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1 check($sformatf("no_stale_%0d", i), 64'(d_ov), 64'd0);
        end

        // Randomised runs on the other widths
        start_rand = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            if (gen_r[0].done && gen_r[1].done && gen_r[2].done) break;
            @(negedge clk);
        end
        check("rand_done", 64'({gen_r[2].done, gen_r[1].done, gen_r[0].done}), 64'd7);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
